sh_ibus_fabric: RTL and testbench



---
 rtl/sh_ibus_fabric.sv | 181 ++++++++++++++++++
 tb/tb_sh_ibus_fabric.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sh_ibus_fabric.sv
// Internal-bus fabric between the SH cache/DMAC master and on-chip peripherals:
// priority read mux, wait aggregation, busy-timeout abort and unmapped-access error capture.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no stall in progress; the counter is idle
// ST_WAIT  | master is stalled; tmo_cnt counts CE_R ticks of continuous wait
// ST_ABORT | timeout fired; stall released, M_DO forced to DEF_DATA for one CE_R period
module sh_ibus_fabric #(
   parameter int NSLV = 8,
   parameter int DW = 32,
   parameter int AW = 32,
   parameter int TMO_W = 8,
   parameter int TMO_MAX = 255,
   parameter logic [DW-1:0] DEF_DATA = {DW{1'b1}}
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             CE_R,
   input  logic             CE_F,
   input  logic             RES_N,
   input  logic [AW-1:0]    M_A,
   input  logic             M_WE,
   input  logic             M_REQ,
   output logic [DW-1:0]    M_DO,
   output logic             M_WAIT,
   input  logic [NSLV-1:0]  S_ACT,
   input  logic [NSLV*DW-1:0] S_DO,
   input  logic [NSLV-1:0]  S_BUSY,
   input  logic             ERR_CLR,
   output logic             ERR_IRQ,
   output logic [1:0]       ERR_TYPE,
   output logic [AW-1:0]    ERR_ADDR,
   output logic             ERR_WE,
   output logic             ERR_OVF
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ABORT = 2'd2
   } state_t;

   localparam bit TMO_EN = (TMO_MAX != 0);
   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);
   localparam logic [TMO_W-1:0] CNT_SAT = {TMO_W{1'b1}};
   localparam logic [TMO_W-1:0] CNT_ONE = TMO_W'(1);

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_UNM  = 2'b01;
   localparam logic [1:0] ERR_TMO  = 2'b10;

   state_t             state, state_nx;
   logic [TMO_W-1:0]   tmo_cnt, cnt_nx;
   logic [NSLV-1:0]    busy_mask, mask_nx;
   logic               tmo_ev;
   logic               unm_ev;
   logic               unm_armed;
   logic               soft_rst;
   logic               clr;
   logic               irq_live;
   logic [DW-1:0]      rd_data;
   logic               wait_hit;

   assign soft_rst = CE_R & ~RES_N;

   // Walk from the top so the lowest active index is the last (winning) assignment.
   always_comb begin
      rd_data = DEF_DATA;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if (S_ACT[i]) rd_data = S_DO[i*DW +: DW];
      end
   end

   assign M_DO     = (state == ST_ABORT) ? DEF_DATA : rd_data;
   assign wait_hit = M_REQ & (|(S_ACT & S_BUSY & ~busy_mask));
   assign M_WAIT   = (state != ST_ABORT) & wait_hit;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         tmo_cnt   <= '0;
         busy_mask <= '0;
      end else if (soft_rst) begin
         state     <= ST_IDLE;
         tmo_cnt   <= '0;
         busy_mask <= '0;
      end else begin
         state     <= state_nx;
         tmo_cnt   <= cnt_nx;
         busy_mask <= mask_nx;
      end
   end

   // Masked slaves stay ignored until they drop busy, so a hung peripheral cannot re-stall the core.
   always_comb begin
      state_nx = state;
      cnt_nx   = tmo_cnt;
      mask_nx  = busy_mask;
      tmo_ev   = 1'b0;
      if (CE_R) begin
         mask_nx = busy_mask & S_BUSY;
         case (state)
            ST_IDLE: begin
               if (M_WAIT) begin
                  state_nx = ST_WAIT;
                  cnt_nx   = CNT_ONE;
               end
            end
            ST_WAIT: begin
               if (!M_WAIT) begin
                  state_nx = ST_IDLE;
                  cnt_nx   = '0;
               end else if (TMO_EN && (tmo_cnt == TMO_LIM)) begin
                  state_nx = ST_ABORT;
                  cnt_nx   = '0;
                  tmo_ev   = 1'b1;
                  mask_nx  = mask_nx | (S_ACT & S_BUSY);
               end else if (tmo_cnt != CNT_SAT) begin
                  cnt_nx = tmo_cnt + CNT_ONE;
               end
            end
            ST_ABORT: begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end
            default: begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   assign unm_ev = CE_F & M_REQ & ~(|S_ACT) & unm_armed;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         unm_armed <= 1'b1;
      end else if (soft_rst) begin
         unm_armed <= 1'b1;
      end else if (!M_REQ) begin
         unm_armed <= 1'b1;
      end else if (unm_ev) begin
         unm_armed <= 1'b0;
      end
   end

   // A clear in the same cycle as a new error frees the record for that error.
   assign clr      = ERR_CLR & CE_R;
   assign irq_live = ERR_IRQ & ~clr;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ERR_IRQ  <= 1'b0;
         ERR_TYPE <= ERR_NONE;
         ERR_ADDR <= '0;
         ERR_WE   <= 1'b0;
         ERR_OVF  <= 1'b0;
      end else if (soft_rst) begin
         ERR_IRQ  <= 1'b0;
         ERR_TYPE <= ERR_NONE;
         ERR_ADDR <= '0;
         ERR_WE   <= 1'b0;
         ERR_OVF  <= 1'b0;
      end else if ((tmo_ev || unm_ev) && !irq_live) begin
         ERR_IRQ  <= 1'b1;
         ERR_TYPE <= tmo_ev ? ERR_TMO : ERR_UNM;
         ERR_ADDR <= M_A;
         ERR_WE   <= M_WE;
         ERR_OVF  <= tmo_ev & unm_ev;
      end else if (tmo_ev || unm_ev) begin
         ERR_OVF  <= 1'b1;
      end else if (clr) begin
         ERR_IRQ  <= 1'b0;
         ERR_TYPE <= ERR_NONE;
         ERR_OVF  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sh_ibus_fabric.sv
// Self-checking bench for sh_ibus_fabric: constant vector table, directed corner sequences
// and randomized traffic compared against a behavioural model of the fabric rules.
module tb_sh_ibus_fabric;

   localparam int NSLV = 8;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TMO_W = 8;
   localparam int TMO_MAX = 12;
   localparam logic [31:0] DEF = 32'hFFFF_FFFF;

   logic clk, rst_n, ce_r, ce_f, res_n;
   logic [AW-1:0] m_a;
   logic m_we, m_req;
   logic [DW-1:0] m_do;
   logic m_wait;
   logic [NSLV-1:0] s_act;
   logic [NSLV*DW-1:0] s_do;
   logic [NSLV-1:0] s_busy;
   logic err_clr, err_irq;
   logic [1:0] err_type;
   logic [AW-1:0] err_addr;
   logic err_we, err_ovf;

   int checks = 0;
   int errors = 0;

   sh_ibus_fabric #(
      .NSLV(NSLV), .DW(DW), .AW(AW), .TMO_W(TMO_W), .TMO_MAX(TMO_MAX), .DEF_DATA(DEF)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CE_F(ce_f), .RES_N(res_n),
      .M_A(m_a), .M_WE(m_we), .M_REQ(m_req), .M_DO(m_do), .M_WAIT(m_wait),
      .S_ACT(s_act), .S_DO(s_do), .S_BUSY(s_busy), .ERR_CLR(err_clr),
      .ERR_IRQ(err_irq), .ERR_TYPE(err_type), .ERR_ADDR(err_addr),
      .ERR_WE(err_we), .ERR_OVF(err_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model state
   bit          md_abort;
   int          md_waited;
   bit [7:0]    md_mask;
   bit          md_reported;
   bit          md_irq;
   bit [1:0]    md_type;
   bit [31:0]   md_addr;
   bit          md_we;
   bit          md_ovf;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_do();
      if (md_abort) return DEF;
      for (int i = 0; i < NSLV; i++)
         if (s_act[i]) return s_do[i*DW +: DW];
      return DEF;
   endfunction

   function automatic bit exp_wait();
      bit any;
      any = 1'b0;
      for (int i = 0; i < NSLV; i++)
         if (s_act[i] && s_busy[i] && !md_mask[i]) any = 1'b1;
      return !md_abort && m_req && any;
   endfunction

   task automatic model_reset();
      md_abort = 0; md_waited = 0; md_mask = '0; md_reported = 0;
      md_irq = 0; md_type = 2'b00; md_addr = '0; md_we = 0; md_ovf = 0;
   endtask

   task automatic model_clock();
      bit w, tmo, unm, clrq, pending;
      if (!rst_n || (ce_r && !res_n)) begin
         model_reset();
         return;
      end
      w = exp_wait();
      tmo = 0;
      unm = 0;
      if (ce_r) begin
         md_mask = md_mask & s_busy;
         if (md_abort) begin
            md_abort = 0;
            md_waited = 0;
         end else if (w) begin
            md_waited++;
            if (TMO_MAX != 0 && md_waited > TMO_MAX) begin
               tmo = 1;
               md_abort = 1;
               md_waited = 0;
               md_mask = md_mask | (s_act & s_busy);
            end
         end else begin
            md_waited = 0;
         end
      end
      if (ce_f && m_req && s_act == 0 && !md_reported) unm = 1;
      if (!m_req) md_reported = 0;
      else if (unm) md_reported = 1;
      clrq = ce_r && err_clr;
      pending = md_irq && !clrq;
      if (tmo || unm) begin
         if (!pending) begin
            md_irq = 1;
            md_type = tmo ? 2'b10 : 2'b01;
            md_addr = m_a;
            md_we = m_we;
            md_ovf = tmo && unm;
         end else begin
            md_ovf = 1;
         end
      end else if (clrq) begin
         md_irq = 0; md_type = 2'b00; md_ovf = 0;
      end
   endtask

   task automatic check_all();
      if (!m_we) chk("m_do", m_do, exp_do());
      chk("m_wait", 32'(m_wait), 32'(exp_wait()));
      chk("err_irq", 32'(err_irq), 32'(md_irq));
      chk("err_type", 32'(err_type), 32'(md_type));
      chk("err_addr", err_addr, md_addr);
      chk("err_we", 32'(err_we), 32'(md_we));
      chk("err_ovf", 32'(err_ovf), 32'(md_ovf));
   endtask

   task automatic step();
      #1;
      if (!rst_n) model_reset();
      check_all();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic tick();
      ce_r = 1'b1; ce_f = 1'b0;
      step();
      ce_r = 1'b0; ce_f = 1'b1;
      step();
      ce_f = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  act;
      logic [7:0]  busy;
      logic        req;
      logic [31:0] exp_do;
      logic        exp_wait;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int hi, n;
      vecs[0] = '{8'h04, 8'h00, 1'b1, 32'h1234_5678, 1'b0};
      vecs[1] = '{8'h82, 8'h00, 1'b1, 32'hA5A5_0001, 1'b0};
      vecs[2] = '{8'h00, 8'hFF, 1'b1, 32'hFFFF_FFFF, 1'b0};
      vecs[3] = '{8'h08, 8'h08, 1'b1, 32'h3333_3333, 1'b1};
      vecs[4] = '{8'h08, 8'h08, 1'b0, 32'h3333_3333, 1'b0};
      vecs[5] = '{8'h81, 8'h80, 1'b1, 32'h1111_0000, 1'b1};
      vecs[6] = '{8'h81, 8'h7E, 1'b1, 32'h1111_0000, 1'b0};
      vecs[7] = '{8'h01, 8'h01, 1'b1, 32'h1111_0000, 1'b1};

      rst_n = 0; ce_r = 0; ce_f = 0; res_n = 1; m_a = '0; m_we = 0; m_req = 0;
      s_act = '0; s_busy = '0; err_clr = 0;
      s_do = {32'h0000_0007, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444,
              32'h3333_3333, 32'h1234_5678, 32'hA5A5_0001, 32'h1111_0000};
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_irq", 32'(err_irq), 32'd0);
      chk("rst_type", 32'(err_type), 32'd0);
      chk("rst_addr", err_addr, 32'd0);
      chk("rst_ovf", 32'(err_ovf), 32'd0);
      chk("rst_wait", 32'(m_wait), 32'd0);
      rst_n = 1;

      // combinational mux / wait table; enables held low so no state moves
      for (int k = 0; k < 8; k++) begin
         s_act = vecs[k].act; s_busy = vecs[k].busy; m_req = vecs[k].req;
         #2;
         chk("tbl_do", m_do, vecs[k].exp_do);
         chk("tbl_wait", 32'(m_wait), 32'(vecs[k].exp_wait));
         chk("tbl_irq", 32'(err_irq), 32'd0);
      end
      m_req = 0; s_act = '0; s_busy = '0;
      @(negedge clk);

      // wait then release
      m_req = 1; s_act = 8'h08; s_busy = 8'h08; m_a = 32'h0000_3000;
      hi = 0;
      for (int k = 0; k < 10; k++) begin
         #1 hi += int'(m_wait);
         tick();
      end
      chk("wait_ticks", 32'(hi), 32'd10);
      s_busy = 8'h00;
      tick();
      chk("release_wait", 32'(m_wait), 32'd0);
      chk("release_irq", 32'(err_irq), 32'd0);
      m_req = 0;
      tick();

      // busy timeout on slave 5
      m_req = 1; s_act = 8'h20; s_busy = 8'h20; m_a = 32'h5000_0050; m_we = 0;
      n = 0;
      #1;
      while (m_wait && n < 40) begin
         tick();
         n++;
      end
      chk("tmo_ticks", 32'(n), 32'(TMO_MAX + 1));
      chk("abort_do", m_do, 32'hFFFF_FFFF);
      chk("tmo_type", 32'(err_type), 32'h2);
      chk("tmo_addr", err_addr, 32'h5000_0050);
      chk("tmo_irq", 32'(err_irq), 32'd1);
      tick();
      chk("post_abort_wait", 32'(m_wait), 32'd0);
      m_req = 0;
      tick();
      m_req = 1; m_a = 32'h5000_0060;
      #1 chk("masked_wait", 32'(m_wait), 32'd0);
      tick();
      s_busy = 8'h00;
      tick();
      s_busy = 8'h20;
      #1 chk("unmask_wait", 32'(m_wait), 32'd1);
      m_req = 0; s_busy = 8'h00;
      tick();

      // unmapped accesses
      err_clr = 1;
      tick();
      err_clr = 0;
      chk("clr_irq", 32'(err_irq), 32'd0);
      m_req = 1; s_act = 8'h00; m_a = 32'h0400_0000; m_we = 0;
      tick();
      chk("unm_type", 32'(err_type), 32'h1);
      chk("unm_addr", err_addr, 32'h0400_0000);
      chk("unm_do", m_do, DEF);
      repeat (3) tick();
      chk("unm_once_ovf", 32'(err_ovf), 32'd0);
      m_req = 0;
      tick();
      m_req = 1; m_a = 32'h0800_0000; m_we = 1;
      tick();
      chk("unm2_ovf", 32'(err_ovf), 32'd1);
      chk("unm2_addr", err_addr, 32'h0400_0000);
      chk("unm2_we", 32'(err_we), 32'd0);
      err_clr = 1;
      tick();
      err_clr = 0;
      chk("clr_held_irq", 32'(err_irq), 32'd0);
      m_req = 0; m_we = 0;
      tick();
      m_req = 1; m_a = 32'h0000_0200;
      tick();
      m_req = 0;
      tick();

      // clear colliding with a new unmapped access
      m_req = 1; m_a = 32'h0000_0100; err_clr = 1;
      tick();
      err_clr = 0;
      chk("coll_irq", 32'(err_irq), 32'd1);
      chk("coll_addr", err_addr, 32'h0000_0100);
      chk("coll_ovf", 32'(err_ovf), 32'd0);
      m_req = 0;
      tick();
      m_req = 1; m_a = 32'h0000_0180; err_clr = 1; ce_r = 1; ce_f = 1;
      step();
      err_clr = 0; ce_r = 0; ce_f = 0;
      chk("coll2_addr", err_addr, 32'h0000_0180);
      chk("coll2_ovf", 32'(err_ovf), 32'd0);
      m_req = 0;
      tick();

      // async reset in the middle of a stall
      s_act = 8'h08; s_busy = 8'h08; m_req = 1; m_a = 32'h0000_0300;
      repeat (3) tick();
      chk("pre_rst_wait", 32'(m_wait), 32'd1);
      rst_n = 0;
      #1;
      chk("mid_rst_irq", 32'(err_irq), 32'd0);
      chk("mid_rst_type", 32'(err_type), 32'd0);
      chk("mid_rst_addr", err_addr, 32'd0);
      chk("mid_rst_we", 32'(err_we), 32'd0);
      chk("mid_rst_ovf", 32'(err_ovf), 32'd0);
      model_reset();
      step();
      rst_n = 1; m_req = 0; s_busy = 8'h00;
      tick();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NSLV; i++) s_do[i*DW +: DW] = $urandom;
         if ($urandom_range(0, 15) == 0) s_busy = 8'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: s_act = 8'h00;
               1: s_act = 8'h01 << $urandom_range(0, 7);
               default: s_act = 8'($urandom & $urandom);
            endcase
         end
         if ($urandom_range(0, 5) == 0) begin
            m_req = ~m_req;
            if (m_req) begin
               m_a = $urandom;
               m_we = 1'($urandom_range(0, 1));
            end
         end
         ce_r = 1'($urandom_range(0, 1));
         ce_f = 1'($urandom_range(0, 1));
         res_n = ($urandom_range(0, 99) != 0);
         err_clr = ($urandom_range(0, 9) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
